// File: rtl/rv32_decode_buf_if.sv
// Fetch-side and execute-side handshake bundle for rv32_decode_buf.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface rv32_decode_buf_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          i_valid;
  logic          o_ready;
  logic [31:0]   i_inst;
  logic [31:0]   i_pc;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_pc;
  logic [4:0]    o_rs1_addr;
  logic [4:0]    o_rs2_addr;
  logic [4:0]    o_rd_addr;
  logic [2:0]    o_funct3;
  logic [31:0]   o_imm;
  logic [13:0]   o_alu;
  logic [7:0]    o_mdu;
  logic [10:0]   o_opcode;
  logic [3:0]    o_exception;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_valid, i_inst, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_funct3,
           o_imm, o_alu, o_mdu, o_opcode, o_exception, o_count
  );

  modport master (
    output i_valid, i_inst, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_rs1_addr, o_rs2_addr, o_rd_addr, o_funct3,
           o_imm, o_alu, o_mdu, o_opcode, o_exception, o_count
  );
endinterface

// File: rtl/rv32_decode_buf.sv
// Buffered RV32I(+M) decode stage: DEPTH-entry instruction FIFO feeding a
// single decoded output register, valid/ready on both sides.
module rv32_decode_buf #(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  rv32_decode_buf_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5, A_AND = 6;
  localparam int A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11, A_GE = 12, A_GEU = 13;

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, valid_q;

  logic [31:0] h_inst, h_pc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] dec_imm;
  logic [13:0] dec_alu;
  logic [7:0]  dec_mdu;
  logic [10:0] dec_opc;
  logic [3:0]  dec_exc;

  logic [31:0] pc_q, imm_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  f3_q;
  logic [13:0] alu_q;
  logic [7:0]  mdu_q;
  logic [10:0] opc_q;
  logic [3:0]  exc_q;

  // Ready depends only on occupancy, so a full FIFO refuses pushes even on a pop cycle.
  assign bus.o_ready = (count < CW'(DEPTH));
  assign push = bus.i_valid && bus.o_ready && !bus.i_flush;
  assign pop  = (count != '0) && (!valid_q || bus.i_ready) && !bus.i_flush;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= bus.i_inst;
      mem_pc[wr_ptr]   <= bus.i_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign h_inst = mem_inst[rd_ptr];
  assign h_pc   = mem_pc[rd_ptr];
  assign f3     = h_inst[14:12];
  assign f7     = h_inst[31:25];

  function automatic logic [13:0] alu_sel(input logic [2:0] fn, input logic alt);
    logic [13:0] r;
    r = '0;
    case (fn)
      3'd0:    r[alt ? A_SUB : A_ADD] = 1'b1;
      3'd1:    r[A_SLL]  = 1'b1;
      3'd2:    r[A_SLT]  = 1'b1;
      3'd3:    r[A_SLTU] = 1'b1;
      3'd4:    r[A_XOR]  = 1'b1;
      3'd5:    r[alt ? A_SRA : A_SRL] = 1'b1;
      3'd6:    r[A_OR]   = 1'b1;
      default: r[A_AND]  = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    dec_opc = '0;
    dec_alu = '0;
    dec_mdu = '0;
    dec_imm = '0;
    dec_exc = '0;
    case (h_inst[6:0])
      7'b0110011: begin
        dec_opc[0] = 1'b1;
        if (f7 == 7'h01 && ENABLE_M) begin
          dec_mdu[f3] = 1'b1;
        end else begin
          dec_alu = alu_sel(f3, h_inst[30]);
          if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
            dec_exc[0] = 1'b1;
        end
      end
      7'b0010011: begin
        dec_opc[1] = 1'b1;
        dec_alu = alu_sel(f3, (f3 == 3'd5) && h_inst[30]);
        dec_imm = {{20{h_inst[31]}}, h_inst[31:20]};
        if ((f3 == 3'd1 && f7 != 7'h00) ||
            (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
          dec_exc[0] = 1'b1;
      end
      7'b0000011: begin
        dec_opc[2] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {{20{h_inst[31]}}, h_inst[31:20]};
      end
      7'b0100011: begin
        dec_opc[3] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
      end
      7'b1100011: begin
        dec_opc[4] = 1'b1;
        dec_imm = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
        case (f3)
          3'd0:    dec_alu[A_EQ]   = 1'b1;
          3'd1:    dec_alu[A_NEQ]  = 1'b1;
          3'd4:    dec_alu[A_SLT]  = 1'b1;
          3'd5:    dec_alu[A_GE]   = 1'b1;
          3'd6:    dec_alu[A_SLTU] = 1'b1;
          3'd7:    dec_alu[A_GEU]  = 1'b1;
          default: dec_exc[0]      = 1'b1;
        endcase
      end
      7'b1101111: begin
        dec_opc[5] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        dec_opc[6] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {{20{h_inst[31]}}, h_inst[31:20]};
      end
      7'b0110111: begin
        dec_opc[7] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {h_inst[31:12], 12'h000};
      end
      7'b0010111: begin
        dec_opc[8] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {h_inst[31:12], 12'h000};
      end
      7'b1110011: begin
        dec_opc[9] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {20'h0, h_inst[31:20]};
        // Privileged ops are recognised only by their full encoding.
        if (f3 == 3'd0) begin
          case (h_inst)
            32'h0000_0073: dec_exc[1] = 1'b1;
            32'h0010_0073: dec_exc[2] = 1'b1;
            32'h3020_0073: dec_exc[3] = 1'b1;
            32'h1050_0073: dec_exc    = '0;
            default:       dec_exc[0] = 1'b1;
          endcase
        end
      end
      7'b0001111: begin
        dec_opc[10] = 1'b1;
        dec_alu[A_ADD] = 1'b1;
        dec_imm = {20'h0, h_inst[31:20]};
      end
      default: dec_exc[0] = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdu_q   <= '0;
      opc_q   <= '0;
      exc_q   <= '0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
    end else if (pop) begin
      valid_q <= 1'b1;
      pc_q    <= h_pc;
      rs1_q   <= h_inst[19:15];
      rs2_q   <= h_inst[24:20];
      rd_q    <= h_inst[11:7];
      f3_q    <= f3;
      imm_q   <= dec_imm;
      alu_q   <= dec_alu;
      mdu_q   <= dec_mdu;
      opc_q   <= dec_opc;
      exc_q   <= dec_exc;
    end else if (valid_q && bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_rs1_addr  = rs1_q;
  assign bus.o_rs2_addr  = rs2_q;
  assign bus.o_rd_addr   = rd_q;
  assign bus.o_funct3    = f3_q;
  assign bus.o_imm       = imm_q;
  assign bus.o_alu       = alu_q;
  assign bus.o_mdu       = mdu_q;
  assign bus.o_opcode    = opc_q;
  assign bus.o_exception = exc_q;
  assign bus.o_count     = count;
endmodule

// File: tb/tb_rv32_decode_buf.sv
// Directed bench for rv32_decode_buf: decode vector table on an RV32I instance,
// M-extension checks on an RV32IM instance, plus backpressure/flush sequences.
module tb_rv32_decode_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0, rdy = 1'b1, fl = 1'b0;
  logic [31:0] inst = '0, pc = '0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  rv32_decode_buf_if #(.DEPTH(2)) b0 ();
  rv32_decode_buf_if #(.DEPTH(2)) b1 ();

  assign b0.i_valid = v;   assign b1.i_valid = v;
  assign b0.i_inst  = inst; assign b1.i_inst  = inst;
  assign b0.i_pc    = pc;  assign b1.i_pc    = pc;
  assign b0.i_flush = fl;  assign b1.i_flush = fl;
  assign b0.i_ready = rdy; assign b1.i_ready = rdy;

  rv32_decode_buf #(.DEPTH(2), .ENABLE_M(1'b0)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  rv32_decode_buf #(.DEPTH(2), .ENABLE_M(1'b1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));

  typedef struct {
    logic [31:0] inst;
    logic [13:0] alu;
    logic [10:0] opc;
    logic [31:0] imm;
    logic [3:0]  exc;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 14'h0001, 11'h002, 32'h00000005, 4'h0, 5'd1};
    vecs[1]  = '{32'h30200073, 14'h0001, 11'h200, 32'h00000302, 4'h8, 5'd0};
    vecs[2]  = '{32'h00100073, 14'h0001, 11'h200, 32'h00000001, 4'h4, 5'd0};
    vecs[3]  = '{32'h10500073, 14'h0001, 11'h200, 32'h00000105, 4'h0, 5'd0};
    vecs[4]  = '{32'h10200073, 14'h0001, 11'h200, 32'h00000102, 4'h1, 5'd0};
    vecs[5]  = '{32'h00000073, 14'h0001, 11'h200, 32'h00000000, 4'h2, 5'd0};
    vecs[6]  = '{32'h022081B3, 14'h0000, 11'h001, 32'h00000000, 4'h1, 5'd3};
    vecs[7]  = '{32'h40109093, 14'h0000, 11'h002, 32'h00000401, 4'h1, 5'd1};
    vecs[8]  = '{32'h00002063, 14'h0000, 11'h010, 32'h00000000, 4'h1, 5'd0};
    vecs[9]  = '{32'h40105093, 14'h0200, 11'h002, 32'h00000401, 4'h0, 5'd1};
    vecs[10] = '{32'h402081B3, 14'h0002, 11'h001, 32'h00000000, 4'h0, 5'd3};
    vecs[11] = '{32'hFE209CE3, 14'h0800, 11'h010, 32'hFFFFFFF8, 4'h0, 5'd25};
    vecs[12] = '{32'h123452B7, 14'h0001, 11'h080, 32'h12345000, 4'h0, 5'd5};
    vecs[13] = '{32'h010000EF, 14'h0001, 11'h020, 32'h00000010, 4'h0, 5'd1};
    vecs[14] = '{32'hFE20AE23, 14'h0001, 11'h008, 32'hFFFFFFFC, 4'h0, 5'd28};
    vecs[15] = '{32'h0000007F, 14'h0000, 11'h000, 32'h00000000, 4'h1, 5'd0};
    vecs[16] = '{32'h00812303, 14'h0001, 11'h004, 32'h00000008, 4'h0, 5'd6};
    vecs[17] = '{32'hFFFFF397, 14'h0001, 11'h100, 32'hFFFFF000, 4'h0, 5'd7};

    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(b0.o_valid), 32'd0);
    chk("rst_ready", 32'(b0.o_ready), 32'd1);
    chk("rst_count", 32'(b0.o_count), 32'd0);
    chk("rst_pc", b0.o_pc, 32'd0);
    chk("rst_imm", b0.o_imm, 32'd0);
    chk("rst_alu", 32'(b0.o_alu), 32'd0);
    chk("rst_opc", 32'(b0.o_opcode), 32'd0);
    chk("rst_exc", 32'(b0.o_exception), 32'd0);

    // One instruction at a time into an idle stage.
    for (int i = 0; i < NV; i++) begin
      inst = vecs[i].inst;
      pc   = 32'h1000 + 32'(i) * 4;
      v    = 1'b1;
      step();
      v = 1'b0;
      chk("lat_not_yet", 32'(b0.o_valid), 32'd0);
      step();
      chk($sformatf("v%0d_valid", i), 32'(b0.o_valid), 32'd1);
      chk($sformatf("v%0d_pc", i), b0.o_pc, 32'h1000 + 32'(i) * 4);
      chk($sformatf("v%0d_opc", i), 32'(b0.o_opcode), 32'(vecs[i].opc));
      chk($sformatf("v%0d_imm", i), b0.o_imm, vecs[i].imm);
      chk($sformatf("v%0d_exc", i), 32'(b0.o_exception), 32'(vecs[i].exc));
      chk($sformatf("v%0d_rd", i), 32'(b0.o_rd_addr), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(b0.o_rs1_addr), 32'(vecs[i].inst[19:15]));
      chk($sformatf("v%0d_rs2", i), 32'(b0.o_rs2_addr), 32'(vecs[i].inst[24:20]));
      chk($sformatf("v%0d_f3", i), 32'(b0.o_funct3), 32'(vecs[i].inst[14:12]));
      chk($sformatf("v%0d_mdu", i), 32'(b0.o_mdu), 32'd0);
      if (!vecs[i].exc[0])
        chk($sformatf("v%0d_alu", i), 32'(b0.o_alu), 32'(vecs[i].alu));
      step();
      chk($sformatf("v%0d_drain", i), 32'(b0.o_valid), 32'd0);
    end

    // M extension on the RV32IM instance.
    inst = 32'h022081B3; pc = 32'h2000; v = 1'b1;
    step(); v = 1'b0; step();
    chk("mul_mdu", 32'(b1.o_mdu), 32'h01);
    chk("mul_alu", 32'(b1.o_alu), 32'h0);
    chk("mul_exc", 32'(b1.o_exception), 32'h0);
    chk("mul_opc", 32'(b1.o_opcode), 32'h001);
    step();
    inst = 32'h0220B1B3; pc = 32'h2004; v = 1'b1;
    step(); v = 1'b0; step();
    chk("mulhu_mdu", 32'(b1.o_mdu), 32'h08);
    chk("mulhu_alu", 32'(b1.o_alu), 32'h0);
    step();

    // Back-to-back stream: one per cycle, in order.
    inst = 32'h00500093;
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        chk($sformatf("tput%0d_valid", k), 32'(b0.o_valid), 32'd1);
        chk($sformatf("tput%0d_pc", k), b0.o_pc, 32'h3000 + 32'(k - 2) * 4);
      end
      v  = (k < 4);
      pc = 32'h3000 + 32'(k) * 4;
      step();
    end
    chk("tput_drain", 32'(b0.o_valid), 32'd0);

    // Backpressure: fill output register plus FIFO, refuse a 4th push, drain in order.
    rdy = 1'b0;
    v = 1'b1; inst = 32'h00500093; pc = 32'h4000;
    step();
    inst = 32'h123452B7; pc = 32'h4004;
    step();
    chk("bp_valid", 32'(b0.o_valid), 32'd1);
    chk("bp_pc_a", b0.o_pc, 32'h4000);
    chk("bp_count1", 32'(b0.o_count), 32'd1);
    inst = 32'h402081B3; pc = 32'h4008;
    step();
    chk("bp_count2", 32'(b0.o_count), 32'd2);
    chk("bp_full_ready", 32'(b0.o_ready), 32'd0);
    chk("bp_hold_pc", b0.o_pc, 32'h4000);
    inst = 32'h0000007F; pc = 32'h400C;
    step();
    chk("bp_no_push_count", 32'(b0.o_count), 32'd2);
    chk("bp_hold_pc2", b0.o_pc, 32'h4000);
    chk("bp_hold_rd", 32'(b0.o_rd_addr), 32'd1);
    chk("bp_hold_imm", b0.o_imm, 32'd5);
    v = 1'b0; rdy = 1'b1;
    step();
    chk("bp_pc_b", b0.o_pc, 32'h4004);
    chk("bp_rd_b", 32'(b0.o_rd_addr), 32'd5);
    chk("bp_count_b", 32'(b0.o_count), 32'd1);
    step();
    chk("bp_pc_c", b0.o_pc, 32'h4008);
    chk("bp_valid_c", 32'(b0.o_valid), 32'd1);
    chk("bp_count_c", 32'(b0.o_count), 32'd0);
    step();
    chk("bp_drained", 32'(b0.o_valid), 32'd0);
    step();
    chk("bp_no_ghost", 32'(b0.o_valid), 32'd0);

    // Flush with a full stage and a concurrent push.
    rdy = 1'b0;
    v = 1'b1; inst = 32'h00500093; pc = 32'h5000;
    step();
    pc = 32'h5004;
    step();
    pc = 32'h5008;
    step();
    chk("fl_pre_count", 32'(b0.o_count), 32'd2);
    chk("fl_pre_valid", 32'(b0.o_valid), 32'd1);
    fl = 1'b1; pc = 32'h500C;
    step();
    chk("fl_count", 32'(b0.o_count), 32'd0);
    chk("fl_valid", 32'(b0.o_valid), 32'd0);
    chk("fl_ready", 32'(b0.o_ready), 32'd1);
    fl = 1'b0; v = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_quiet%0d", k), 32'(b0.o_valid), 32'd0);
    end
    v = 1'b1; inst = 32'h00500093; pc = 32'h6000;
    step(); v = 1'b0; step();
    chk("post_fl_valid", 32'(b0.o_valid), 32'd1);
    chk("post_fl_pc", b0.o_pc, 32'h6000);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
